mac_timestep_controller: RTL and testbench
==========================================

# mac_timestep_controller

Sequences the array of 5-connection MAC units through initialisation and timesteps, and shares the single broadcast source-address bus between several spike requesters. Runs the init (`set`) window, then repeats: a spike-delivery window, then a `clear` phase that makes every MAC latch its spikes and present its weighted sum. Sits between the spike-routing fabric (requesters) and the MAC units' `source_address`/`set`/`clear`/`done` pins, replacing the free-running counter-derived `set`/`clear` timing.

## Interface
- `N_REQ`, 4: number of spike requesters (≥2).
- `ADDR_W`, 12: source-address width.
- `TIMESTEP_CYCLES`, 64: length of the RUN window in cycles (≥2).
- `INIT_CYCLES`, 4: cycles `mac_set` is held high.
- `CLEAR_MIN`, 2: minimum cycles `mac_clear` is held high.
- `DONE_TIMEOUT`, 255: max CLEAR cycles before forced exit.

- `CLK_ctrl` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: leave IDLE and begin INIT.
- `stop` in 1: finish the current timestep, then return to IDLE.
- `req_valid` in N_REQ: requester i has a source address pending.
- `req_addr` in N_REQ*ADDR_W: requester i address at bits [i*ADDR_W +: ADDR_W].
- `req_ready` out N_REQ: one-hot grant; transfer when valid&ready.
- `src_addr` out ADDR_W: broadcast source address to MAC units.
- `src_valid` out 1: `src_addr` carries a spike this cycle.
- `mac_set` out 1: MAC initialisation.
- `mac_clear` out 1: MAC end-of-timestep.
- `mac_done` in 1: AND of all MAC `done` outputs.
- `timestep` out 16: completed-timestep count.
- `busy` out 1: state ≠ IDLE.
- `done_timeout` out 1: sticky error flag.

## Operation
- States: IDLE, INIT, RUN, CLEAR.
- IDLE: all outputs low. `start`=1 → INIT; `timestep` cleared to 0 on this transition.
- INIT: `mac_set`=1 for exactly INIT_CYCLES cycles, then RUN with cycle counter = 0.
- RUN: counter 0..TIMESTEP_CYCLES-1. In cycles 0..TIMESTEP_CYCLES-2, round-robin grant among `req_valid`. Search starts at last-granted index +1, mod N_REQ. After reset the pointer is N_REQ-1, so requester 0 has first priority. At most one `req_ready` bit is high, and only where `req_valid` is high (combinational from registered state and `req_valid`). The final RUN cycle grants nothing (drain cycle). Then → CLEAR.
- Requesters hold `req_valid`/`req_addr` stable until granted. Ungranted requests persist across timesteps; none are dropped.
- CLEAR: `mac_clear`=1, `req_ready`=0. Exit when held ≥ CLEAR_MIN cycles and `mac_done`=1, or after DONE_TIMEOUT cycles (sets `done_timeout`, cleared only by reset). On exit `timestep` increments, wrapping 0xFFFF→0. Next state is IDLE if stop is pending, else RUN with counter = 0.
- `stop` sampled in any non-IDLE state sets stop-pending; cleared on IDLE entry. `start` is ignored outside IDLE. `start` and `stop` together in IDLE: start wins, stop is ignored.
- `reset` mid-operation: immediate return to IDLE. Every output, the counter, the RR pointer (N_REQ-1), stop-pending and `done_timeout` go to 0 asynchronously. A spike in flight is lost.

## Timing
- Reset values: every output 0.
- Grant latency: grant in cycle t → `src_addr`=granted address, `src_valid`=1 in cycle t+1 only (registered). Otherwise `src_valid`=0 and `src_addr` holds its last value.
- The drain cycle guarantees `src_valid`=0 whenever `mac_clear`=1.
- Period per timestep = TIMESTEP_CYCLES + CLEAR length. CLEAR length = max(CLEAR_MIN, first cycle `mac_done`=1), capped at DONE_TIMEOUT.
- `mac_set` and `mac_clear` are never high together; both are registered.
- Max spikes per timestep = TIMESTEP_CYCLES-1.

## Structure
- Shared package `mac_ctrl_pkg`: state enum, default ADDR_W, and a timestep-width constant (16).
- One sub-module `rr_arbiter` (parameter N): inputs `req`, `enable`, `CLK_ctrl`, `reset`; outputs one-hot `grant`. Holds the pointer and advances it only on a grant.
- The top level holds the FSM, counters, address register and flags.

## Test plan
- Reset then `start`: `mac_set` high for exactly 4 cycles, then RUN, counter 0, `timestep`=0.
- All 4 requesters valid continuously, addresses 0,1,2,7: grants go 0,1,2,3,0,… with one per cycle. `src_addr` sequence 0,1,2,7,… one cycle after each grant. 63 spikes per timestep; no `src_valid` during the drain cycle or CLEAR.
- `mac_done` rises on the 5th CLEAR cycle: `mac_clear` is high for exactly 5 cycles and `timestep` goes 0→1. With `mac_done` tied high, `mac_clear` is high for exactly 2 cycles.
- `mac_done` tied low: CLEAR lasts 255 cycles, `done_timeout`=1 and stays 1, and the next RUN starts.
- `stop` pulsed mid-RUN: the timestep completes, CLEAR runs, then IDLE with `busy`=0. The pending request from requester 2 is still unserved with `req_ready`=0.
- `reset` asserted mid-RUN with a grant in flight: all outputs 0 immediately and `src_valid` never asserts. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC timestep controller slice.
package mac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_CLEAR
    } ctrl_state_t;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int TIMESTEP_W     = 16;

    // Width of one counter that can hold every window length used by the FSM.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mac_timestep_controller_if.sv
// Requester handshake plus the broadcast bus towards the MAC array.
// The controller uses the master view; requesters and MAC units use slave.
interface mac_timestep_controller_if
    import mac_ctrl_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]       src_addr;
    logic                    src_valid;
    logic                    mac_set;
    logic                    mac_clear;
    logic                    mac_done;

    modport master (
        input  req_valid, req_addr, mac_done,
        output req_ready, src_addr, src_valid, mac_set, mac_clear
    );

    modport slave (
        output req_valid, req_addr, mac_done,
        input  req_ready, src_addr, src_valid, mac_set, mac_clear
    );

endinterface

// File: rtl/mac_timestep_controller_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         CLK_ctrl,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] idx;
    logic          found;

    // Pick the first requester after the pointer, wrapping around once.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        idx       = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && enable && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // The pointer moves only when somebody actually wins; reset favours index 0.
    always_ff @(posedge CLK_ctrl or posedge reset) begin
        if (reset) begin
            ptr <= PW'(N - 1);
        end else if (found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mac_timestep_controller.sv
// Sequences MAC init / spike delivery / clear and shares the source-address bus.
module mac_timestep_controller
    import mac_ctrl_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int ADDR_W          = DEFAULT_ADDR_W,
    parameter int TIMESTEP_CYCLES = 64,
    parameter int INIT_CYCLES     = 4,
    parameter int CLEAR_MIN       = 2,
    parameter int DONE_TIMEOUT    = 255
) (
    input  logic                  CLK_ctrl,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    mac_timestep_controller_if.master bus,
    output logic [TIMESTEP_W-1:0] timestep,
    output logic                  busy,
    output logic                  done_timeout
);
    localparam int CNT_W = cnt_width(TIMESTEP_CYCLES, DONE_TIMEOUT, INIT_CYCLES);

    ctrl_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              stop_pending;
    logic [N_REQ-1:0]  grant;
    logic              grant_en;
    logic [ADDR_W-1:0] grant_addr;
    logic              clear_min_met;
    logic              clear_expired;
    logic              done_exit;

    // The last RUN cycle is a drain cycle so nothing is in flight during CLEAR.
    assign grant_en      = (state == ST_RUN) && (cnt != CNT_W'(TIMESTEP_CYCLES - 1));
    assign clear_min_met = (cnt >= CNT_W'(CLEAR_MIN - 1));
    assign clear_expired = (cnt == CNT_W'(DONE_TIMEOUT - 1));
    assign done_exit     = clear_min_met && bus.mac_done;
    assign busy          = (state != ST_IDLE);
    assign bus.req_ready = grant;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .CLK_ctrl (CLK_ctrl),
        .reset    (reset),
        .req      (bus.req_valid),
        .enable   (grant_en),
        .grant    (grant)
    );

    // Select the address of whichever requester holds the grant this cycle.
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Main sequencer: window counters, registered MAC strobes, spike register, flags.
    always_ff @(posedge CLK_ctrl or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            stop_pending  <= 1'b0;
            bus.mac_set   <= 1'b0;
            bus.mac_clear <= 1'b0;
            bus.src_valid <= 1'b0;
            bus.src_addr  <= '0;
            timestep      <= '0;
            done_timeout  <= 1'b0;
        end else begin
            bus.src_valid <= |grant;
            if (|grant) bus.src_addr <= grant_addr;

            if (state != ST_IDLE && stop) stop_pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_INIT;
                        cnt         <= '0;
                        bus.mac_set <= 1'b1;
                        timestep    <= '0;
                    end
                end
                ST_INIT: begin
                    if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        bus.mac_set <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(TIMESTEP_CYCLES - 1)) begin
                        state         <= ST_CLEAR;
                        cnt           <= '0;
                        bus.mac_clear <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (done_exit || clear_expired) begin
                        bus.mac_clear <= 1'b0;
                        cnt           <= '0;
                        timestep      <= timestep + TIMESTEP_W'(1);
                        if (!done_exit) done_timeout <= 1'b1;
                        if (stop_pending || stop) begin
                            state        <= ST_IDLE;
                            stop_pending <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_timestep_controller.sv
// Scoreboard bench for mac_timestep_controller: expected spike addresses are
// queued as timesteps are launched and popped by a monitor on every src_valid.
module tb_mac_timestep_controller;
    import mac_ctrl_pkg::*;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 12;

    logic                  CLK_ctrl = 1'b0;
    logic                  reset    = 1'b0;
    logic                  start    = 1'b0;
    logic                  stop     = 1'b0;
    logic [TIMESTEP_W-1:0] timestep;
    logic                  busy;
    logic                  done_timeout;

    mac_timestep_controller_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) bus ();

    mac_timestep_controller #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .TIMESTEP_CYCLES(64),
        .INIT_CYCLES(4), .CLEAR_MIN(2), .DONE_TIMEOUT(255)
    ) dut (
        .CLK_ctrl     (CLK_ctrl),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .bus          (bus),
        .timestep     (timestep),
        .busy         (busy),
        .done_timeout (done_timeout)
    );

    always #5 CLK_ctrl = ~CLK_ctrl;

    int                n_vec = 0;
    int                n_miss = 0;
    int                spike_idx = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_tab[4] = '{12'd0, 12'd1, 12'd2, 12'd7};
    logic              inv_ok;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    // All four requesters stay valid, so the stream cycles 0,1,2,7 across timesteps.
    task automatic pushExpected(input int spikes);
        for (int i = 0; i < spikes; i++) begin
            exp_q.push_back(addr_tab[spike_idx % 4]);
            spike_idx++;
        end
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_stop);
        @(negedge CLK_ctrl);
        start = s_start;
        stop  = s_stop;
        @(negedge CLK_ctrl);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic measureSet(output int n);
        n = 0;
        while (bus.mac_set && n < 20) begin
            n++;
            @(negedge CLK_ctrl);
        end
    endtask

    task automatic measureRun(input int stop_at, output int n);
        n = 0;
        while (!bus.mac_clear && n < 200) begin
            stop = (n == stop_at);
            n++;
            @(negedge CLK_ctrl);
        end
        stop = 1'b0;
    endtask

    task automatic measureClear(input int done_at, output int c);
        c = 0;
        while (bus.mac_clear && c < 300) begin
            c++;
            if (c == done_at) bus.mac_done = 1'b1;
            @(negedge CLK_ctrl);
        end
    endtask

    // Monitor: protocol invariants every cycle, and scoreboard pop on each spike.
    always @(negedge CLK_ctrl) begin
        if (!reset) begin
            inv_ok = ($countones(bus.req_ready) <= 1)
                  && ((bus.req_ready & ~bus.req_valid) == '0)
                  && !(bus.src_valid && bus.mac_clear)
                  && !(bus.mac_set && bus.mac_clear)
                  && !(bus.mac_clear && (bus.req_ready != '0));
            checkOutput("invariants", {31'd0, inv_ok}, 32'd1);
            if (bus.src_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL unexpected_spike: actual src_addr %0d, required no spike",
                             bus.src_addr);
                end else begin
                    checkOutput("src_addr", {20'd0, bus.src_addr}, {20'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_addr  = {12'd7, 12'd2, 12'd1, 12'd0};
        bus.mac_done  = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_src_valid", {31'd0, bus.src_valid}, 0);
        checkOutput("rst_src_addr", {20'd0, bus.src_addr}, 0);
        checkOutput("rst_mac_set", {31'd0, bus.mac_set}, 0);
        checkOutput("rst_mac_clear", {31'd0, bus.mac_clear}, 0);
        checkOutput("rst_req_ready", {28'd0, bus.req_ready}, 0);
        checkOutput("rst_timestep", {16'd0, timestep}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done_timeout", {31'd0, done_timeout}, 0);
        @(negedge CLK_ctrl);
        @(negedge CLK_ctrl);
        reset = 1'b0;
        $display("[TB] reset released");

        // Timestep 1: INIT window, full RUN, mac_done rising on the 5th CLEAR cycle
        bus.req_valid = 4'hF;
        pushExpected(63);
        applyStimulus(1'b1, 1'b0);
        measureSet(n);
        checkOutput("set_len", n, 4);
        checkOutput("ts_after_start", {16'd0, timestep}, 0);
        checkOutput("busy_run", {31'd0, busy}, 1);
        measureRun(-1, n);
        checkOutput("run_len_1", n, 64);
        measureClear(5, n);
        bus.mac_done = 1'b0;
        checkOutput("clear_len_done5", n, 5);
        checkOutput("ts_1", {16'd0, timestep}, 1);
        checkOutput("spikes_left_1", exp_q.size(), 0);

        // Timestep 2: mac_done tied high gives the minimum CLEAR
        pushExpected(63);
        bus.mac_done = 1'b1;
        measureRun(-1, n);
        checkOutput("run_len_2", n, 64);
        measureClear(0, n);
        bus.mac_done = 1'b0;
        checkOutput("clear_len_min", n, 2);
        checkOutput("ts_2", {16'd0, timestep}, 2);
        checkOutput("spikes_left_2", exp_q.size(), 0);
        checkOutput("no_timeout_yet", {31'd0, done_timeout}, 0);

        // Timestep 3: mac_done tied low forces the timeout exit
        pushExpected(63);
        measureRun(-1, n);
        checkOutput("run_len_3", n, 64);
        measureClear(0, n);
        checkOutput("clear_len_timeout", n, 255);
        checkOutput("done_timeout_set", {31'd0, done_timeout}, 1);
        checkOutput("ts_3", {16'd0, timestep}, 3);
        checkOutput("busy_after_timeout", {31'd0, busy}, 1);
        checkOutput("spikes_left_3", exp_q.size(), 0);

        // Timestep 4: stop pulsed mid-RUN, timestep completes then IDLE
        pushExpected(63);
        measureRun(10, n);
        checkOutput("run_len_stop", n, 64);
        bus.mac_done = 1'b1;
        measureClear(0, n);
        bus.mac_done = 1'b0;
        checkOutput("clear_len_stop", n, 2);
        checkOutput("busy_idle", {31'd0, busy}, 0);
        checkOutput("ts_4", {16'd0, timestep}, 4);
        checkOutput("timeout_sticky", {31'd0, done_timeout}, 1);
        repeat (5) @(negedge CLK_ctrl);
        checkOutput("idle_req_ready", {28'd0, bus.req_ready}, 0);
        checkOutput("idle_stays", {31'd0, busy}, 0);
        checkOutput("spikes_left_4", exp_q.size(), 0);

        // start and stop together: start wins; then reset with a grant in flight
        bus.req_valid = 4'b0010;
        applyStimulus(1'b1, 1'b1);
        measureSet(n);
        checkOutput("set_len_2", n, 4);
        checkOutput("ts_restart", {16'd0, timestep}, 0);
        checkOutput("grant_in_flight", {28'd0, bus.req_ready}, 32'h2);
        reset = 1'b1;
        #1;
        checkOutput("midrst_src_valid", {31'd0, bus.src_valid}, 0);
        checkOutput("midrst_busy", {31'd0, busy}, 0);
        checkOutput("midrst_req_ready", {28'd0, bus.req_ready}, 0);
        checkOutput("midrst_done_timeout", {31'd0, done_timeout}, 0);
        checkOutput("midrst_timestep", {16'd0, timestep}, 0);
        @(negedge CLK_ctrl);
        checkOutput("midrst_src_valid_held", {31'd0, bus.src_valid}, 0);
        reset = 1'b0;

        // Pointer returns to N_REQ-1: requester 0 beats requester 3
        bus.req_valid = 4'b1001;
        exp_q.push_back(12'd0);
        exp_q.push_back(12'd7);
        applyStimulus(1'b1, 1'b0);
        measureSet(n);
        checkOutput("set_len_3", n, 4);
        checkOutput("first_grant_req0", {28'd0, bus.req_ready}, 32'h1);
        @(posedge CLK_ctrl);
        #1 bus.req_valid = 4'b1000;
        @(negedge CLK_ctrl);
        checkOutput("second_grant_req3", {28'd0, bus.req_ready}, 32'h8);
        @(posedge CLK_ctrl);
        #1 bus.req_valid = 4'b0000;
        repeat (3) @(negedge CLK_ctrl);
        checkOutput("spikes_left_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
